// File: rtl/square_motion_controller_pkg.sv
// Shared definitions for the player-square controller, spike detector and renderer:
// state encoding, coordinate width and a small state-class helper.
package square_motion_controller_pkg;

  localparam int COORD_W = 11;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_GROUNDED = 3'd1;
  localparam logic [STATE_W-1:0] ST_RISING   = 3'd2;
  localparam logic [STATE_W-1:0] ST_APEX     = 3'd3;
  localparam logic [STATE_W-1:0] ST_FALLING  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DEAD     = 3'd5;

  typedef logic [COORD_W-1:0] coord_t;

  // True in the states where the world scrolls under the square.
  function automatic logic is_running(input logic [STATE_W-1:0] st);
    return (st == ST_GROUNDED) || (st == ST_RISING) ||
           (st == ST_APEX)     || (st == ST_FALLING);
  endfunction

endpackage

// File: rtl/square_motion_controller_frame_tick_generator.sv
// Free-running frame counter; tick is high on the last cycle of every frame.
// Shared with the renderer so both agree on frame boundaries.
module frame_tick_generator #(
  parameter int CLOCKS_PER_FRAME = 833334
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (CLOCKS_PER_FRAME < 2) ? 1 : $clog2(CLOCKS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_FRAME - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/square_motion_controller.sv
// Player-square kinematics: frame strobe, scroll step, jump arc on y, and a
// DEAD freeze after a spike hit that only reset clears.
module square_motion_controller
  import square_motion_controller_pkg::*;
#(
  parameter int     CLOCKS_PER_FRAME = 833334,
  parameter coord_t SQUARE_X         = 11'd40,
  parameter coord_t GROUND_Y         = 11'd100,
  parameter coord_t JUMP_HEIGHT      = 11'd20,
  parameter int     APEX_FRAMES      = 4,
  parameter coord_t SCROLL_STEP      = 11'd1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               jump_button,
  input  logic               is_spike_hit,
  output logic               update_screen,
  output logic [COORD_W-1:0] square_bottom_left_corner_x_pos,
  output logic [COORD_W-1:0] square_bottom_left_corner_y_pos,
  output logic [COORD_W-1:0] move_counter,
  output logic               is_jump_button_pressed,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int APEX_W = (APEX_FRAMES < 2) ? 1 : $clog2(APEX_FRAMES);
  localparam logic [APEX_W-1:0] APEX_LAST = APEX_W'(APEX_FRAMES - 1);

  logic               tick;
  logic [STATE_W-1:0] state, state_nxt;
  coord_t             height, height_nxt;
  logic [APEX_W-1:0]  apex_cnt, apex_nxt;
  logic               sync1, sync2, sync_prev;
  logic               jump_rise;

  frame_tick_generator #(
    .CLOCKS_PER_FRAME(CLOCKS_PER_FRAME)
  ) u_frame_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // The button is asynchronous; only the second flop's output is trusted.
  assign jump_rise = sync2 & ~sync_prev;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    height_nxt = height;
    apex_nxt   = apex_cnt;
    if (is_spike_hit) begin
      state_nxt = ST_DEAD;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_GROUNDED;
        end
        ST_GROUNDED: begin
          if (is_jump_button_pressed) begin
            height_nxt = COORD_W'(1);
            apex_nxt   = '0;
            state_nxt  = (JUMP_HEIGHT == COORD_W'(1)) ? ST_APEX : ST_RISING;
          end
        end
        ST_RISING: begin
          height_nxt = height + COORD_W'(1);
          if (height_nxt == JUMP_HEIGHT) begin
            state_nxt = ST_APEX;
            apex_nxt  = '0;
          end
        end
        ST_APEX: begin
          if (apex_cnt == APEX_LAST) state_nxt = ST_FALLING;
          else                       apex_nxt  = apex_cnt + APEX_W'(1);
        end
        ST_FALLING: begin
          height_nxt = height - COORD_W'(1);
          if (height == COORD_W'(1)) state_nxt = ST_GROUNDED;
        end
        ST_DEAD: begin
          state_nxt = ST_DEAD;
        end
        default: begin
          state_nxt  = ST_IDLE;
          height_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                  <= ST_IDLE;
      height                 <= '0;
      apex_cnt               <= '0;
      sync1                  <= 1'b0;
      sync2                  <= 1'b0;
      sync_prev              <= 1'b0;
      update_screen          <= 1'b0;
      move_counter           <= '0;
      is_jump_button_pressed <= 1'b0;
    end else begin
      sync1         <= jump_button;
      sync2         <= sync1;
      sync_prev     <= sync2;
      state         <= state_nxt;
      height        <= height_nxt;
      apex_cnt      <= apex_nxt;
      update_screen <= tick;
      if (tick) begin
        // An edge arriving on the tick itself survives into the next frame.
        is_jump_button_pressed <= jump_rise;
        move_counter           <= is_running(state_nxt) ? SCROLL_STEP : '0;
      end else if (jump_rise) begin
        is_jump_button_pressed <= 1'b1;
      end
    end
  end

  assign square_bottom_left_corner_x_pos = SQUARE_X;
  assign square_bottom_left_corner_y_pos = GROUND_Y - height;
  assign state_dbg                       = state;

endmodule

// File: tb/tb_square_motion_controller.sv
// Self-checking bench for square_motion_controller: directed scenarios plus a
// randomized run compared cycle by cycle against a frame-level arc model.
module tb_square_motion_controller;

  localparam int CPF     = 4;
  localparam int JH      = 3;
  localparam int AF      = 2;
  localparam int GY      = 100;
  localparam int SX      = 40;
  localparam int STEP    = 1;
  localparam int ARC_LEN = 2 * JH + AF;

  logic        clock        = 1'b0;
  logic        reset        = 1'b0;
  logic        start        = 1'b0;
  logic        jump_button  = 1'b0;
  logic        is_spike_hit = 1'b0;
  logic        update_screen;
  logic [10:0] x_pos, y_pos, move_counter;
  logic        is_jump_button_pressed;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  square_motion_controller #(
    .CLOCKS_PER_FRAME(CPF),
    .SQUARE_X        (11'(SX)),
    .GROUND_Y        (11'(GY)),
    .JUMP_HEIGHT     (11'(JH)),
    .APEX_FRAMES     (AF),
    .SCROLL_STEP     (11'(STEP))
  ) dut (
    .clock                           (clock),
    .reset                           (reset),
    .start                           (start),
    .jump_button                     (jump_button),
    .is_spike_hit                    (is_spike_hit),
    .update_screen                   (update_screen),
    .square_bottom_left_corner_x_pos (x_pos),
    .square_bottom_left_corner_y_pos (y_pos),
    .move_counter                    (move_counter),
    .is_jump_button_pressed          (is_jump_button_pressed),
    .state_dbg                       (state_dbg)
  );

  // Reference model: the whole jump is a precomputed list of y values, one per
  // frame; m_k is how many entries have been shown (0 = standing on the ground).
  int arc [ARC_LEN];
  int m_pos = 0, m_k = 0, m_mc = 0;
  bit m_idle = 1, m_dead = 0, m_req = 0, m_strobe = 0;
  bit m_s1 = 0, m_s2 = 0, m_s3 = 0;
  bit m_tick, m_rise;

  function automatic int exp_y();
    return (m_k == 0) ? GY : arc[m_k-1];
  endfunction

  function automatic int exp_state();
    if (m_idle)            return 0;
    if (m_dead)            return 5;
    if (m_k == 0)          return 1;
    if (m_k < JH)          return 2;
    if (m_k < JH + AF)     return 3;
    return 4;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_pos = 0; m_k = 0; m_mc = 0;
      m_idle = 1; m_dead = 0; m_req = 0; m_strobe = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
    end else begin
      m_tick = (m_pos == CPF - 1);
      m_rise = m_s2 && !m_s3;
      if (is_spike_hit) m_dead = 1;
      if (m_tick) begin
        if (!m_dead) begin
          if (m_idle) begin
            if (start) m_idle = 0;
          end else if (m_k != 0) begin
            m_k++;
            if (m_k == ARC_LEN) m_k = 0;
          end else if (m_req) begin
            m_k = 1;
          end
        end
        m_mc     = (m_idle || m_dead) ? 0 : STEP;
        m_req    = m_rise;
        m_strobe = 1;
      end else begin
        m_req    = m_req || m_rise;
        m_strobe = 0;
      end
      m_pos = m_tick ? 0 : m_pos + 1;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = jump_button;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * CPF && !ok; i++) begin
      @(negedge clock);
      ok = (update_screen === 1'b1);
    end
  endtask

  task automatic press();
    jump_button = 1'b1;
    cyc(2);
    jump_button = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; jump_button = 1'b0; is_spike_hit = 1'b0;
    cyc(2);
    n_checks++; if (update_screen !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %0b want 0", update_screen); end
    n_checks++; if (y_pos !== 11'(GY)) begin n_fail++; $display("FAIL reset_y: got %0d want %0d", y_pos, GY); end
    n_checks++; if (x_pos !== 11'(SX)) begin n_fail++; $display("FAIL reset_x: got %0d want %0d", x_pos, SX); end
    n_checks++; if (move_counter !== 11'd0) begin n_fail++; $display("FAIL reset_move: got %0d want 0", move_counter); end
    n_checks++; if (is_jump_button_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", is_jump_button_pressed); end
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    reset = 1'b1;
  endtask

  task automatic test_idle();
    int last = -1;
    int nstrobe = 0;
    for (int c = 1; c <= 5 * CPF; c++) begin
      cyc(1);
      n_checks++; if (update_screen !== m_strobe) begin n_fail++; $display("FAIL idle_strobe c=%0d: got %0b want %0b", c, update_screen, m_strobe); end
      if (update_screen === 1'b1) begin
        nstrobe++;
        n_checks++;
        if ((last < 0 && c != CPF) || (last >= 0 && c - last != CPF)) begin
          n_fail++; $display("FAIL idle_period c=%0d: previous strobe at %0d, want spacing %0d", c, last, CPF);
        end
        last = c;
      end
      n_checks++;
      if (y_pos !== 11'(GY) || move_counter !== 11'd0 || state_dbg !== 3'd0) begin
        n_fail++; $display("FAIL idle_outputs c=%0d: got y=%0d move=%0d state=%0d want y=%0d move=0 state=0", c, y_pos, move_counter, state_dbg, GY);
      end
    end
    n_checks++; if (nstrobe != 5) begin n_fail++; $display("FAIL idle_strobe_count: got %0d want 5", nstrobe); end
  endtask

  task automatic test_jump_arc(input bit extra);
    int exp_list [9] = '{99, 98, 97, 97, 97, 98, 99, 100, 100};
    bit ok;
    if (state_dbg === 3'd0) begin
      start = 1'b1; wait_strobe(ok); start = 1'b0;
    end else begin
      wait_strobe(ok);
    end
    n_checks++;
    if (!ok || state_dbg !== 3'd1 || y_pos !== 11'(GY)) begin
      n_fail++; $display("FAIL arc_grounded: got ok=%0b state=%0d y=%0d want ok=1 state=1 y=%0d", ok, state_dbg, y_pos, GY);
    end
    press(); cyc(1);
    n_checks++; if (is_jump_button_pressed !== 1'b1) begin n_fail++; $display("FAIL arc_req_latched: got %0b want 1", is_jump_button_pressed); end
    for (int s = 0; s < 9; s++) begin
      wait_strobe(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL arc_timeout s=%0d: no strobe within %0d cycles", s, 3 * CPF); break; end
      n_checks++; if (y_pos !== 11'(exp_list[s])) begin n_fail++; $display("FAIL arc_y s=%0d extra=%0b: got %0d want %0d", s, extra, y_pos, exp_list[s]); end
      n_checks++; if (move_counter !== 11'(STEP)) begin n_fail++; $display("FAIL arc_move s=%0d: got %0d want %0d", s, move_counter, STEP); end
      n_checks++; if (state_dbg !== 3'(exp_state())) begin n_fail++; $display("FAIL arc_state s=%0d: got %0d want %0d", s, state_dbg, exp_state()); end
      n_checks++; if (is_jump_button_pressed !== 1'b0) begin n_fail++; $display("FAIL arc_req_cleared s=%0d: got %0b want 0", s, is_jump_button_pressed); end
      if (extra && (s == 0 || s == 3)) begin
        press(); cyc(1);
        n_checks++; if (is_jump_button_pressed !== 1'b1) begin n_fail++; $display("FAIL arc_ignored_req s=%0d: got %0b want 1", s, is_jump_button_pressed); end
      end
    end
    n_checks++; if (state_dbg !== 3'd1) begin n_fail++; $display("FAIL arc_end_state: got %0d want 1", state_dbg); end
  endtask

  task automatic test_spike();
    bit ok;
    wait_strobe(ok);
    press();
    wait_strobe(ok);
    wait_strobe(ok);
    n_checks++; if (!ok || y_pos !== 11'(GY - 2)) begin n_fail++; $display("FAIL spike_setup: got ok=%0b y=%0d want ok=1 y=%0d", ok, y_pos, GY - 2); end
    is_spike_hit = 1'b1; cyc(1); is_spike_hit = 1'b0;
    n_checks++; if (state_dbg !== 3'd5) begin n_fail++; $display("FAIL spike_dead: got %0d want 5", state_dbg); end
    press();
    for (int s = 0; s < 3; s++) begin
      wait_strobe(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL spike_strobe s=%0d: no strobe while dead", s); break; end
      n_checks++;
      if (y_pos !== 11'(GY - 2) || move_counter !== 11'd0 || state_dbg !== 3'd5) begin
        n_fail++; $display("FAIL spike_frozen s=%0d: got y=%0d move=%0d state=%0d want y=%0d move=0 state=5", s, y_pos, move_counter, state_dbg, GY - 2);
      end
    end
  endtask

  task automatic test_reset_mid_jump();
    bit ok;
    int c;
    start = 1'b1; wait_strobe(ok); start = 1'b0;
    press();
    repeat (3) wait_strobe(ok);
    n_checks++; if (!ok || state_dbg !== 3'd3 || y_pos !== 11'(GY - JH)) begin n_fail++; $display("FAIL rstjump_setup: got state=%0d y=%0d want state=3 y=%0d", state_dbg, y_pos, GY - JH); end
    reset = 1'b0; cyc(1);
    n_checks++;
    if (y_pos !== 11'(GY) || move_counter !== 11'd0 || update_screen !== 1'b0 || state_dbg !== 3'd0 || is_jump_button_pressed !== 1'b0) begin
      n_fail++; $display("FAIL rstjump_values: got y=%0d move=%0d strobe=%0b state=%0d req=%0b want y=%0d move=0 strobe=0 state=0 req=0",
                         y_pos, move_counter, update_screen, state_dbg, is_jump_button_pressed, GY);
    end
    reset = 1'b1;
    c = 0;
    for (int i = 1; i <= 3 * CPF && c == 0; i++) begin
      cyc(1);
      if (update_screen === 1'b1) c = i;
    end
    n_checks++; if (c != CPF) begin n_fail++; $display("FAIL rstjump_first_strobe: got %0d cycles want %0d", c, CPF); end
  endtask

  task automatic test_jump_on_tick();
    bit ok;
    start = 1'b1; wait_strobe(ok); start = 1'b0;
    n_checks++; if (state_dbg !== 3'd1) begin n_fail++; $display("FAIL tickjump_grounded: got %0d want 1", state_dbg); end
    cyc(1);
    jump_button = 1'b1;
    wait_strobe(ok);
    n_checks++;
    if (!ok || is_jump_button_pressed !== 1'b1 || y_pos !== 11'(GY) || state_dbg !== 3'd1) begin
      n_fail++; $display("FAIL tickjump_latched: got req=%0b y=%0d state=%0d want req=1 y=%0d state=1", is_jump_button_pressed, y_pos, state_dbg, GY);
    end
    wait_strobe(ok);
    n_checks++;
    if (!ok || is_jump_button_pressed !== 1'b0 || y_pos !== 11'(GY - 1) || state_dbg !== 3'd2) begin
      n_fail++; $display("FAIL tickjump_rising: got req=%0b y=%0d state=%0d want req=0 y=%0d state=2", is_jump_button_pressed, y_pos, state_dbg, GY - 1);
    end
    wait_strobe(ok);
    n_checks++;
    if (!ok || is_jump_button_pressed !== 1'b0 || y_pos !== 11'(GY - 2)) begin
      n_fail++; $display("FAIL tickjump_hold: got req=%0b y=%0d want req=0 y=%0d", is_jump_button_pressed, y_pos, GY - 2);
    end
    jump_button = 1'b0;
  endtask

  task automatic test_random();
    reset = 1'b0; cyc(2); reset = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      cyc(1);
      n_checks++; if (update_screen !== m_strobe) begin n_fail++; $display("FAIL rand_strobe c=%0d: got %0b want %0b", c, update_screen, m_strobe); end
      n_checks++; if (y_pos !== 11'(exp_y())) begin n_fail++; $display("FAIL rand_y c=%0d: got %0d want %0d", c, y_pos, exp_y()); end
      n_checks++; if (x_pos !== 11'(SX)) begin n_fail++; $display("FAIL rand_x c=%0d: got %0d want %0d", c, x_pos, SX); end
      n_checks++; if (move_counter !== 11'(m_mc)) begin n_fail++; $display("FAIL rand_move c=%0d: got %0d want %0d", c, move_counter, m_mc); end
      n_checks++; if (is_jump_button_pressed !== m_req) begin n_fail++; $display("FAIL rand_req c=%0d: got %0b want %0b", c, is_jump_button_pressed, m_req); end
      n_checks++; if (state_dbg !== 3'(exp_state())) begin n_fail++; $display("FAIL rand_state c=%0d: got %0d want %0d", c, state_dbg, exp_state()); end
      reset        = ($urandom_range(0, 249) != 0);
      start        = ($urandom_range(0, 2) == 0);
      is_spike_hit = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) jump_button = ~jump_button;
    end
    reset = 1'b1; is_spike_hit = 1'b0; jump_button = 1'b0; start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < ARC_LEN; i++) begin
      if (i < JH)           arc[i] = GY - (i + 1);
      else if (i < JH + AF) arc[i] = GY - JH;
      else                  arc[i] = GY - (JH - 1 - (i - JH - AF));
    end
    test_reset();
    test_idle();
    test_jump_arc(1'b0);
    test_jump_arc(1'b1);
    test_spike();
    test_reset();
    test_reset_mid_jump();
    test_jump_on_tick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/square_motion_controller.md
Name: square_motion_controller

Overview:
- Produces the player-square kinematics and frame timing consumed by the spike collision detector and the renderer.
- Generates the per-frame update_screen strobe and the per-frame scroll step (move_counter).
- Turns raw jump-button presses into a jump arc on the square's bottom-left y coordinate.
- Freezes motion once a spike hit is reported; only reset recovers.

Parameters:
- CLOCKS_PER_FRAME, 833334, clock cycles per frame (50 MHz / 60 Hz); must be at least 2.
- SQUARE_X, 11'd40, fixed bottom-left x of the square.
- GROUND_Y, 11'd100, bottom-left y when grounded; screen y grows downward.
- JUMP_HEIGHT, 11'd20, apex height in pixels above GROUND_Y; must be 1 to GROUND_Y.
- APEX_FRAMES, 4, frames held at apex.
- SCROLL_STEP, 11'd1, pixels scrolled per frame while running.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; leaves IDLE when high at a frame tick.
- jump_button  in  1  raw asynchronous button, active-high.
- is_spike_hit  in  1  collision flag from the detector.
- update_screen  out  1  one-cycle frame strobe.
- square_bottom_left_corner_x_pos  out  11  always SQUARE_X.
- square_bottom_left_corner_y_pos  out  11  current square y.
- move_counter  out  11  scroll pixels applied this frame.
- is_jump_button_pressed  out  1  latched, not-yet-consumed jump request.
- state_dbg  out  3  current FSM state, for LEDs.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, frame counter=0, height=0, apex counter=0, synchronizer flops=0.
  - Outputs: update_screen=0, y=GROUND_Y, x=SQUARE_X, move_counter=0, is_jump_button_pressed=0.
  - Reset mid-jump or in DEAD returns to these values on the next edge.
- Frame tick:
  - Frame counter runs 0 to CLOCKS_PER_FRAME-1, then wraps.
  - The wrap cycle is the tick. All state, y and move_counter updates happen only at ticks.
  - update_screen is registered. It is high for exactly the one cycle after the tick edge.
  - During that high cycle, y and move_counter already hold the new frame's values, so consumers sample coherent data.
  - update_screen keeps pulsing in every state, including IDLE and DEAD.
- Jump input:
  - jump_button passes through a 2-flop synchronizer, then rising-edge detection.
  - A rising edge sets the request latch. The latch is cleared at the next tick in every state.
  - The request is consumed only when the state is GROUNDED at that tick.
  - Holding the button does not re-trigger; a new rising edge is required.
  - An edge on the same cycle as a tick is latched and serviced at the following tick.
- States (all transitions evaluated at ticks unless noted):
  - IDLE: move_counter=0, y=GROUND_Y. Goes to GROUNDED when start==1.
  - GROUNDED: move_counter=SCROLL_STEP. With a request pending: height=1, y=GROUND_Y-1, go to RISING.
  - RISING: height +1, y -1 each tick. When height reaches JUMP_HEIGHT, go to APEX and clear the apex counter.
  - APEX: y held; apex counter +1 each tick. After APEX_FRAMES ticks, go to FALLING.
  - FALLING: height -1, y +1 each tick. When height reaches 0, y equals GROUND_Y and the state goes to GROUNDED on the same tick.
  - DEAD: move_counter=0, y frozen at its last value. Exit only via reset. state_dbg=5.
  - move_counter=SCROLL_STEP in GROUNDED, RISING, APEX and FALLING.
- Spike hit:
  - is_spike_hit==1 on any non-tick cycle forces DEAD at the next edge.
  - At a tick, DEAD takes priority over any other transition or jump.
  - The strobe for that tick still fires, with move_counter=0 and y unchanged.
- Arithmetic:
  - All coordinates are 11-bit unsigned.
  - y never goes below GROUND_Y-JUMP_HEIGHT and never exceeds GROUND_Y; parameter legality guarantees no wrap.
  - Frame counter width is $clog2(CLOCKS_PER_FRAME).

Decomposition:
- Shared package: the 3-bit state encoding (IDLE=0, GROUNDED=1, RISING=2, APEX=3, FALLING=4, DEAD=5) and the COORD_W=11 constant. The detector and renderer use the same package.
- One sub-module, frame_tick_generator:
  - Parameter CLOCKS_PER_FRAME.
  - Ports clock, reset (active-low, synchronous), tick.
  - Also reusable by the renderer.

Test Plan (CLOCKS_PER_FRAME=4, JUMP_HEIGHT=3, APEX_FRAMES=2, GROUND_Y=100, SCROLL_STEP=1):
1. Reset then idle, start=0 for 5 frames -> update_screen high 1 cycle every 4 cycles; y=100; move_counter=0; state_dbg=0.
2. start=1 for one tick, then one jump edge -> y over successive strobes: 100, 99, 98, 97, 97, 97, 98, 99, 100, then stays 100; move_counter=1 throughout; ends GROUNDED.
3. Press jump while RISING, then again at the APEX second frame -> both ignored; is_jump_button_pressed clears at the next tick; arc identical to scenario 2, no second jump.
4. is_spike_hit pulsed one cycle mid-RISING at y=98 -> next edge state_dbg=5; later strobes show y=98, move_counter=0; update_screen keeps pulsing; a jump edge has no effect.
5. reset=0 for one cycle during APEX -> next edge: y=100, move_counter=0, update_screen=0, state IDLE, frame counter restarts (first strobe 4 cycles later).
6. Jump edge on the exact tick cycle while GROUNDED -> is_jump_button_pressed=1 for one frame; RISING begins at the following tick (y=99 on that strobe).
